// File: rtl/montgomery_mul_issue.sv
// Issue stage for the Montgomery reduction pipeline: 2-stage multiply, reducer strobe,
// and in-order tag re-attachment for returning results, bounded by a credit counter.
module montgomery_mul_issue #(
   parameter int unsigned W     = 12,
   parameter int unsigned IDXW  = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    in_a,
   input  logic [W-1:0]    in_b,
   input  logic [IDXW-1:0] in_idx,
   output logic            red_en,
   output logic [25:0]     red_x,
   input  logic            red_valid,
   input  logic [14:0]     red_y,
   output logic            out_valid,
   output logic [14:0]     out_y,
   output logic [IDXW-1:0] out_idx,
   output logic            err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned PW = 2 * W;
   localparam int unsigned XW = 26;
   localparam int unsigned YW = 15;

   localparam logic [CW-1:0] CntOne = CW'(1);
   localparam logic [CW-1:0] CntMax = CW'(DEPTH);
   localparam logic [AW:0]   PtrOne = (AW + 1)'(1);

   logic            rst_n_q;
   logic            accept;
   logic            push;
   logic            pop;
   logic            fifo_empty;
   logic            fifo_full;

   logic            v1_q;
   logic [W-1:0]    a1_q;
   logic [W-1:0]    b1_q;
   logic [IDXW-1:0] idx1_q;
   logic [PW-1:0]   prod;

   logic            red_en_q;
   logic [XW-1:0]   red_x_q;

   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;

   logic [AW:0]     wr_ptr_q;
   logic [AW:0]     rd_ptr_q;
   logic [IDXW-1:0] tag_mem [DEPTH];

   logic            out_valid_q;
   logic [YW-1:0]   out_y_q;
   logic [IDXW-1:0] out_idx_q;
   logic            err_q;

   // Ready depends only on registered state; no path from red_valid.
   assign in_ready   = rst_n_q && (cnt_q < CntMax);
   assign accept     = in_valid && in_ready;
   assign push       = v1_q;
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop        = red_valid && !fifo_empty;
   assign prod       = PW'(a1_q) * PW'(b1_q);

   always_comb begin
      cnt_d = cnt_q;
      unique case ({accept, pop})
         2'b10:   cnt_d = cnt_q + CntOne;
         2'b01:   cnt_d = cnt_q - CntOne;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rst_n_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         rst_n_q <= 1'b1;
         cnt_q   <= cnt_d;
      end
   end

   // Stage 1: capture operands; the pipeline never stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         a1_q   <= '0;
         b1_q   <= '0;
         idx1_q <= '0;
      end else begin
         v1_q   <= accept;
         a1_q   <= in_a;
         b1_q   <= in_b;
         idx1_q <= in_idx;
      end
   end

   // Stage 2: product to the reducer as a one-cycle beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         red_en_q <= 1'b0;
         red_x_q  <= '0;
      end else begin
         red_en_q <= v1_q;
         red_x_q  <= XW'(prod);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrOne;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wr_ptr_q[AW-1:0]] <= idx1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_idx_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= pop;
         if (pop) begin
            out_y_q   <= red_y;
            out_idx_q <= tag_mem[rd_ptr_q[AW-1:0]];
         end
         if (red_valid && fifo_empty) begin
            err_q <= 1'b1;
         end
      end
   end

   assign red_en    = red_en_q;
   assign red_x     = red_x_q;
   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_idx   = out_idx_q;
   assign err       = err_q;

   // Credits bound the FIFO occupancy, so neither of these can fire in a correct system.
   no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));
   cnt_bound:   assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CntMax);

endmodule

// File: tb/tb_montgomery_mul_issue.sv
// Scoreboard bench for montgomery_mul_issue: randomized pairs, reducer model, in-order tag check.
module tb_montgomery_mul_issue;

   localparam int W     = 12;
   localparam int IDXW  = 8;
   localparam int DEPTH = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [W-1:0]    in_a = '0;
   logic [W-1:0]    in_b = '0;
   logic [IDXW-1:0] in_idx = '0;
   logic            red_en;
   logic [25:0]     red_x;
   logic            red_valid = 1'b0;
   logic [14:0]     red_y = '0;
   logic            out_valid;
   logic [14:0]     out_y;
   logic [IDXW-1:0] out_idx;
   logic            err;

   montgomery_mul_issue #(.W(W), .IDXW(IDXW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_idx    (in_idx),
      .red_en    (red_en),
      .red_x     (red_x),
      .red_valid (red_valid),
      .red_y     (red_y),
      .out_valid (out_valid),
      .out_y     (out_y),
      .out_idx   (out_idx),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct { int due; int idx; int x; } exp_x_t;
   typedef struct { int due; int idx; int y; } exp_out_t;
   typedef struct { int due; int y; } ret_t;

   exp_x_t   exp_x_q[$];
   int       inflight_q[$];
   exp_out_t exp_out_q[$];
   ret_t     ret_q[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit auto_ret = 1'b0;
   int ret_lo = 4;
   int ret_hi = 4;
   bit exp_err = 1'b0;

   // Outstanding-operation model: accepts minus matched returns since the last reset.
   int acc_total = 0, pop_total = 0;
   int acc_seen = 0, pop_seen = 0, base_acc = 0, base_pop = 0;
   bit rstq = 1'b0;
   logic exp_ready;
   assign exp_ready = rstq && (((acc_seen - base_acc) - (pop_seen - base_pop)) < DEPTH);

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rstq     <= rst_n;
      acc_seen <= acc_total;
      pop_seen <= pop_total;
      if (!rst_n) begin
         base_acc <= acc_total;
         base_pop <= pop_total;
      end
   end

   task automatic check(input bit ok, input string name, input longint act, input longint req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents red_en or out_valid.
   always @(negedge clk) begin : monitor
      exp_x_t   e;
      exp_out_t o;
      bit       has;
      if (cyc > 0) begin
         check(in_ready === exp_ready, "in_ready", longint'(in_ready), longint'(exp_ready));
         check(err === exp_err, "err", longint'(err), longint'(exp_err));
         if (red_en === 1'b1) begin
            has = exp_x_q.size() > 0;
            check(has, "red_en_expected", 1, longint'(has));
            if (has) begin
               e = exp_x_q.pop_front();
               check(e.due == cyc, "red_en_latency", cyc, e.due);
               check(red_x === 26'(e.x), "red_x", longint'(red_x), e.x);
               inflight_q.push_back(e.idx);
               if (auto_ret) ret_q.push_back('{cyc + int'($urandom_range(ret_lo, ret_hi)), -1});
            end
         end else if (exp_x_q.size() > 0 && exp_x_q[0].due <= cyc) begin
            e = exp_x_q.pop_front();
            check(red_en === 1'b1, "red_en_missing", longint'(red_en), 1);
         end
         if (out_valid === 1'b1) begin
            has = exp_out_q.size() > 0;
            check(has, "out_valid_expected", 1, longint'(has));
            if (has) begin
               o = exp_out_q.pop_front();
               check(o.due == cyc, "out_latency", cyc, o.due);
               check(out_y === 15'(o.y), "out_y", longint'(out_y), o.y);
               check(out_idx === IDXW'(o.idx), "out_idx", longint'(out_idx), o.idx);
            end
         end else if (exp_out_q.size() > 0 && exp_out_q[0].due <= cyc) begin
            o = exp_out_q.pop_front();
            check(out_valid === 1'b1, "out_valid_missing", longint'(out_valid), 1);
         end
      end
   end

   // Reducer model: in-order, one result per cycle, fires when the scheduled cycle arrives.
   always @(negedge clk) begin : reducer
      ret_t     r;
      exp_out_t o;
      int       y;
      #2;
      if (rst_n && ret_q.size() > 0 && ret_q[0].due <= cyc) begin
         r = ret_q.pop_front();
         y = (r.y < 0) ? int'($urandom_range(0, 32767)) : r.y;
         red_valid = 1'b1;
         red_y     = 15'(y);
         if (inflight_q.size() > 0) begin
            o.due = cyc + 1;
            o.idx = inflight_q.pop_front();
            o.y   = y;
            exp_out_q.push_back(o);
            pop_total++;
         end else begin
            exp_err = 1'b1;
         end
      end else begin
         red_valid = 1'b0;
         red_y     = 15'($urandom);
      end
   end

   task automatic drive(input bit v, input int a, input int b, input int idx, output bit acc);
      @(negedge clk);
      #2;
      in_valid = v;
      in_a     = W'(a);
      in_b     = W'(b);
      in_idx   = IDXW'(idx);
      #1;
      acc = v && in_ready && rst_n;
      if (acc) begin
         exp_x_q.push_back('{cyc + 2, idx, a * b});
         acc_total++;
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      repeat (n) drive(1'b0, 0, 0, 0, acc);
   endtask

   task automatic send(input int a, input int b, input int idx);
      bit acc;
      int tries;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 50) begin
         drive(1'b1, a, b, idx, acc);
         tries++;
      end
      check(acc, "send_accepted", tries, 50);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((exp_x_q.size() + inflight_q.size() + ret_q.size() + exp_out_q.size()) > 0
             && guard < 300) begin
         if (!auto_ret && inflight_q.size() > ret_q.size()) ret_q.push_back('{cyc + 1, -1});
         idle(1);
         guard++;
      end
      check(guard < 300, "drain_done", guard, 300);
      idle(2);
   endtask

   task automatic do_reset(input int n);
      logic [52:0] outs;
      @(negedge clk);
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      exp_x_q.delete();
      inflight_q.delete();
      exp_out_q.delete();
      ret_q.delete();
      exp_err  = 1'b0;
      repeat (n) begin
         @(negedge clk);
         #1;
      end
      outs = {red_en, red_x, out_valid, out_y, out_idx, err, in_ready};
      check(outs === '0, "reset_outputs", longint'(outs), 0);
      rst_n = 1'b1;
   endtask

   initial begin : stim
      bit acc;
      int nxt;
      int cnt_acc;

      do_reset(3);
      idle(2);

      // Result strobe with nothing issued.
      auto_ret = 1'b0;
      ret_q.push_back('{cyc + 1, -1});
      idle(4);

      // Single operation with known values.
      send(3328, 3328, 'h5A);
      idle(3);
      ret_q.push_back('{cyc + 1, 1234});
      idle(3);

      // Fill all credits, then release one.
      nxt = 0;
      for (int c = 0; c < 10; c++) begin
         drive(1'b1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), nxt, acc);
         if (acc) nxt++;
      end
      check(nxt == DEPTH, "full_accepts", nxt, DEPTH);
      ret_q.push_back('{cyc + 1, -1});
      for (int c = 0; c < 10 && nxt == DEPTH; c++) begin
         drive(1'b1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), nxt, acc);
         if (acc) nxt++;
      end
      check(nxt == DEPTH + 1, "accept_after_credit", nxt, DEPTH + 1);
      drain();

      // Stream across pointer wrap with fixed return latency.
      auto_ret = 1'b1;
      ret_lo = 4;
      ret_hi = 4;
      for (int i = 0; i < 20; i++)
         send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), i);
      drain();

      // Accept and return in the same cycle at three outstanding.
      auto_ret = 1'b0;
      for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 4095)), 4095, 100 + i);
      idle(3);
      ret_q.push_back('{cyc + 1, -1});
      send(4095, int'($urandom_range(0, 4095)), 103);
      cnt_acc = 0;
      for (int c = 0; c < 7; c++) begin
         drive(1'b1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
               104 + cnt_acc, acc);
         if (acc) cnt_acc++;
      end
      check(cnt_acc == 5, "fill_after_simultaneous", cnt_acc, 5);
      drain();

      // Randomized traffic with varying reducer latency.
      auto_ret = 1'b1;
      ret_lo = 1;
      ret_hi = 6;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 255)));
      end
      drain();

      // Reset with operations in flight.
      auto_ret = 1'b0;
      for (int i = 0; i < 3; i++)
         send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 200 + i);
      do_reset(2);
      idle(6);
      send(1, 4095, 'hC3);
      drain();

      check((exp_x_q.size() + inflight_q.size() + exp_out_q.size() + ret_q.size()) == 0,
            "queues_empty", exp_x_q.size() + inflight_q.size() + exp_out_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/montgomery_mul_issue.md
# montgomery_mul_issue

Front-end issue stage for the Montgomery reduction pipeline. It accepts coefficient pairs (a, b, idx) over a valid/ready handshake and forms the 24-bit product in a 2-stage pipeline. It drives the product to the reducer as a one-cycle `en` + 26-bit `X` beat, then re-attaches each returning reduced result to its idx through an in-order tag FIFO. A credit counter bounds outstanding operations, because the reducer cannot be stalled.

## Interface
- `W`, 12, coefficient width
- `IDXW`, 8, tag/index width
- `DEPTH`, 8, max outstanding operations (tag FIFO depth, power of 2)
- `clk`  in  1  clock
- `rst_n`  in  1  reset; synchronous, active-low
- `in_valid`  in  1  input pair valid
- `in_ready`  out  1  block can accept a pair this cycle
- `in_a`  in  W  coefficient a
- `in_b`  in  W  coefficient b
- `in_idx`  in  IDXW  caller tag
- `red_en`  out  1  one-cycle strobe to reducer, one per product
- `red_x`  out  26  product to reducer, `{2'b0, a*b}`
- `red_valid`  in  1  reducer result strobe
- `red_y`  in  15  reducer result
- `out_valid`  out  1  tagged result valid (one cycle)
- `out_y`  out  15  registered copy of `red_y`
- `out_idx`  out  IDXW  tag of that result
- `err`  out  1  sticky: `red_valid` arrived with the tag FIFO empty

## Operation
- **Accept.** An accept happens when `in_valid && in_ready` on a rising edge.
- **Stage 1 (S1).** Registers a, b and idx, plus a valid bit `v1`.
- **Stage 2 (S2).**
  - Computes `p = a1*b1` as an unsigned 24-bit value.
  - Registers `red_x = {2'b0, p}`.
  - Sets `red_en = v1`, so `red_en` is high for exactly one cycle per accepted pair.
  - Pushes idx1 into the tag FIFO on the same edge.
- **Pipeline flow.** The pipeline never stalls, and S1/S2 advance every cycle.
- **Credit counter `cnt`** (0..DEPTH, width clog2(DEPTH)+1).
  - +1 on accept.
  - −1 on `red_valid` when the FIFO is non-empty.
  - Unchanged when both happen in the same cycle.
- **`in_ready`.** `in_ready = rst_n_q && (cnt < DEPTH)`, evaluated combinationally from registered state. `rst_n_q` is a registered copy of `rst_n`, so `in_ready` is 0 during reset and the first cycle after it.
- **Tag FIFO.**
  - Circular buffer with rd/wr pointers of clog2(DEPTH) bits plus a wrap bit.
  - Push and pop in the same cycle are both performed.
  - Overflow cannot occur because credits are bounded by DEPTH; a push when full is a design error, and assertions flag it.
- **Return path.** On `red_valid` with the FIFO non-empty:
  - Pop the FIFO.
  - Next cycle: `out_valid=1`, `out_y=red_y`, `out_idx=popped tag`.
- **Return error.** On `red_valid` with the FIFO empty: no pop, `cnt` unchanged, `err←1`, `out_valid` stays 0.
- **Ordering.** Results are matched strictly in order, because the reducer is in-order and has fixed latency.
- **Reset values.** Synchronous reset clears all state: `v1`, `red_en`, `red_x`, `cnt`, pointers, `out_valid`, `out_y`, `out_idx`, `err` and `rst_n_q` are all 0. Mid-operation reset discards in-flight S1/S2 data and all tags.

## Timing
- **Accept to `red_en`.** Accept at edge k puts the pair in S1 after edge k. `red_en`/`red_x` are high in the cycle after edge k+1, i.e. 2 cycles after accept.
- **Throughput.** One accept per cycle while `cnt < DEPTH`. Back-to-back accepts produce back-to-back `red_en`.
- **Return latency.** `out_valid` follows `red_valid` by exactly 1 cycle.
- **Credit release.** The credit is released on the `red_valid` edge. `in_ready` can rise the cycle after `red_valid` while `cnt` was DEPTH.
- **Full with simultaneous return.** With `cnt==DEPTH`, `in_ready` is 0 even if `red_valid` is high that cycle. There is no combinational path from `red_valid` to `in_ready`.
- **`err` timing.** `err` sets on the edge of the offending `red_valid` and is cleared only by reset.

## Test plan
- **Single operation.** Accept a=3328, b=3328, idx=0x5A.
  - 2 cycles later: `red_en=1` for 1 cycle with `red_x`=11075584.
  - Drive `red_valid`, `red_y`=1234: `out_valid` next cycle with `out_y`=1234, `out_idx`=0x5A.
- **Full / credit.** Hold `in_valid` for 10 cycles (idx 0..9) with no `red_valid`.
  - Exactly 8 accepts, and `in_ready` drops after the 8th.
  - One `red_valid` pulse: `in_ready`=1 the next cycle; idx 8 is then accepted.
- **Ordering and wrap.** Stream 20 pairs (idx 0..19), returning `red_valid` 4 cycles after each `red_en`. `out_idx` must be 0..19 in order across pointer wrap.
- **Simultaneous push/pop.** At `cnt`=3, accept and `red_valid` in the same cycle. `cnt` stays 3, and FIFO contents and order are preserved.
- **Empty return.** `red_valid` after reset with nothing issued: `err`=1, `out_valid`=0, `cnt`=0, and a subsequent normal operation still completes correctly.
- **Reset mid-flight.** Assert `rst_n`=0 with 3 operations in flight.
  - All outputs are 0 and `in_ready`=0 during reset, then `in_ready`=1 one cycle after release.
  - No stale `red_en` or `out_valid` afterwards.
